// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - two-way set-associative write-through read cache; define CACHE_EN to compile in the tag/data storage
module cache_controller #(
   parameter int SETS  = 64,
   parameter int TAG_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   output logic [31:0] rdata,
   output logic        ready,
   output logic [31:0] sram_address,
   output logic [31:0] sram_wdata,
   output logic        sram_read,
   output logic        sram_write,
   input  logic [63:0] sram_rdata,
   input  logic        sram_ready
);
   localparam int IDX_W = $clog2(SETS);

   typedef enum logic [1:0] {IDLE, RMISS, WRITE} state_t;

   state_t      state_q, state_d;
   logic        sram_read_q, sram_read_d;
   logic        sram_write_q, sram_write_d;
   logic [31:0] sram_address_q, sram_address_d;
   logic [31:0] sram_wdata_q, sram_wdata_d;
   logic [31:0] a;
   logic        wsel;
   logic [31:0] fill_word;
   logic        hit;
   logic [31:0] hit_word;

   // Data memory starts at 1024, so the cache geometry is relative to that base
   assign a         = address - 32'd1024;
   assign wsel      = a[2];
   assign fill_word = wsel ? sram_rdata[63:32] : sram_rdata[31:0];

`ifdef CACHE_EN
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [SETS-1:0]  valid0_q, valid0_d, valid1_q, valid1_d, lru_q, lru_d;
   logic [TAG_W-1:0] tag0_mem [SETS];
   logic [TAG_W-1:0] tag1_mem [SETS];
   logic [63:0]      data0_mem [SETS];
   logic [63:0]      data1_mem [SETS];
   logic             hit0, hit1;
   logic [63:0]      hit_line;
   logic             fill_en, fill_way, wr_en, wr_way;
   logic             unused_addr;

   assign idx         = a[3 +: IDX_W];
   assign tag         = a[3 + IDX_W +: TAG_W];
   assign unused_addr = ^{a[31:3 + IDX_W + TAG_W], a[1:0]};
   assign hit0        = valid0_q[idx] && (tag0_mem[idx] == tag);
   assign hit1        = valid1_q[idx] && (tag1_mem[idx] == tag);
   assign hit         = hit0 | hit1;
   assign hit_line    = hit1 ? data1_mem[idx] : data0_mem[idx];
   assign hit_word    = wsel ? hit_line[63:32] : hit_line[31:0];

   always_comb begin
      valid0_d = valid0_q;
      valid1_d = valid1_q;
      lru_d    = lru_q;
      fill_en  = (state_q == RMISS) && sram_ready;
      fill_way = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);
      wr_en    = (state_q == WRITE) && sram_ready && hit;
      wr_way   = hit1;
      if ((state_q == IDLE) && MEM_R_EN && !MEM_W_EN && hit)
         lru_d[idx] = ~hit1;
      if (fill_en) begin
         if (fill_way)
            valid1_d[idx] = 1'b1;
         else
            valid0_d[idx] = 1'b1;
         lru_d[idx] = ~fill_way;
      end
      if (wr_en)
         lru_d[idx] = ~wr_way;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid0_q <= '0;
         valid1_q <= '0;
         lru_q    <= '0;
      end else begin
         valid0_q <= valid0_d;
         valid1_q <= valid1_d;
         lru_q    <= lru_d;
      end
   end

   // Tag/data arrays need no reset: the valid bits gate every use
   always_ff @(posedge clk) begin
      if (fill_en && !fill_way) begin
         tag0_mem[idx]  <= tag;
         data0_mem[idx] <= sram_rdata;
      end
      if (fill_en && fill_way) begin
         tag1_mem[idx]  <= tag;
         data1_mem[idx] <= sram_rdata;
      end
      if (wr_en && !wr_way) begin
         if (wsel) data0_mem[idx][63:32] <= wdata;
         else      data0_mem[idx][31:0]  <= wdata;
      end
      if (wr_en && wr_way) begin
         if (wsel) data1_mem[idx][63:32] <= wdata;
         else      data1_mem[idx][31:0]  <= wdata;
      end
   end
`else
   logic unused_addr;

   assign unused_addr = ^{a[31:3 + IDX_W + TAG_W], a[2 + IDX_W + TAG_W:3], a[1:0]};
   assign hit         = 1'b0;
   assign hit_word    = '0;
`endif

   always_comb begin
      state_d        = state_q;
      sram_read_d    = sram_read_q;
      sram_write_d   = sram_write_q;
      sram_address_d = sram_address_q;
      sram_wdata_d   = sram_wdata_q;
      ready          = 1'b1;
      rdata          = '0;
      case (state_q)
         IDLE: begin
            if (MEM_W_EN) begin
               state_d        = WRITE;
               sram_write_d   = 1'b1;
               sram_address_d = address;
               sram_wdata_d   = wdata;
               ready          = 1'b0;
            end else if (MEM_R_EN) begin
               if (hit) begin
                  rdata = hit_word;
               end else begin
                  state_d        = RMISS;
                  sram_read_d    = 1'b1;
                  sram_address_d = {address[31:3], 1'b0, address[1:0]};
                  ready          = 1'b0;
               end
            end
         end
         RMISS: begin
            ready = sram_ready;
            if (sram_ready) begin
               rdata       = fill_word;
               state_d     = IDLE;
               sram_read_d = 1'b0;
            end
         end
         WRITE: begin
            ready = sram_ready;
            if (sram_ready) begin
               state_d      = IDLE;
               sram_write_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         sram_read_q    <= 1'b0;
         sram_write_q   <= 1'b0;
         sram_address_q <= '0;
         sram_wdata_q   <= '0;
      end else begin
         state_q        <= state_d;
         sram_read_q    <= sram_read_d;
         sram_write_q   <= sram_write_d;
         sram_address_q <= sram_address_d;
         sram_wdata_q   <= sram_wdata_d;
      end
   end

   assign sram_read    = sram_read_q;
   assign sram_write   = sram_write_q;
   assign sram_address = sram_address_q;
   assign sram_wdata   = sram_wdata_q;

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - randomized self-checking bench for cache_controller against a set/way reference model
module tb_cache_controller;
   localparam int SETS = 64;
`ifdef CACHE_EN
   localparam bit CEN = 1'b1;
`else
   localparam bit CEN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] address = '0;
   logic [31:0] wdata = '0;
   logic        MEM_R_EN = 1'b0;
   logic        MEM_W_EN = 1'b0;
   logic [31:0] rdata;
   logic        ready;
   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic        sram_read;
   logic        sram_write;
   logic [63:0] sram_rdata = '0;
   logic        sram_ready = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   bit          m_v   [2][SETS];
   int          m_t   [2][SETS];
   logic [31:0] m_d   [2][SETS][2];
   bit          m_lru [SETS];

   cache_controller dut (
      .clk(clk), .rst(rst), .address(address), .wdata(wdata),
      .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
      .sram_address(sram_address), .sram_wdata(sram_wdata),
      .sram_read(sram_read), .sram_write(sram_write),
      .sram_rdata(sram_rdata), .sram_ready(sram_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void split(input logic [31:0] addr, output int s, output int t, output int w);
      logic [31:0] a;
      a = addr - 32'd1024;
      s = int'((a / 8) % SETS);
      t = int'((a / 512) % 1024);
      w = int'((a / 4) % 2);
   endfunction

   function automatic int lookup(input logic [31:0] addr);
      int s, t, w;
      split(addr, s, t, w);
      if (!CEN) return -1;
      for (int k = 0; k < 2; k++)
         if (m_v[k][s] && m_t[k][s] == t) return k;
      return -1;
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < 2; k++)
         for (int s = 0; s < SETS; s++) m_v[k][s] = 1'b0;
      for (int s = 0; s < SETS; s++) m_lru[s] = 1'b0;
   endfunction

   task automatic run_op(input bit is_wr, input logic [31:0] addr, input logic [31:0] wd, input int lat);
      int s, t, w, way, vic;
      logic [63:0] blk;
      split(addr, s, t, w);
      way = lookup(addr);
      @(negedge clk);
      address  = addr;
      wdata    = wd;
      MEM_W_EN = is_wr;
      MEM_R_EN = !is_wr;
      #1;
      if (!is_wr && way >= 0) begin
         check("hit_ready", ready, 1);
         check("hit_rdata", rdata, m_d[way][s][w]);
         @(posedge clk);
         #1;
         MEM_R_EN = 1'b0;
         m_lru[s] = (way == 0);
         check("hit_no_sram_read", sram_read, 0);
         return;
      end
      check("req_ready_low", ready, 0);
      blk = {$urandom, $urandom};
      for (int c = 0; c <= lat; c++) begin
         @(negedge clk);
         if (c == lat) begin
            sram_rdata = blk;
            sram_ready = 1'b1;
         end
         #1;
         if (is_wr) begin
            check("sram_write", sram_write, 1);
            check("wr_addr", sram_address, addr);
            check("wr_data", sram_wdata, wd);
         end else begin
            check("sram_read", sram_read, 1);
            check("rd_addr", sram_address, addr & ~32'd4);
         end
         check("busy_ready", ready, c == lat);
         if (c == lat && !is_wr)
            check("miss_rdata", rdata, w ? blk[63:32] : blk[31:0]);
      end
      @(posedge clk);
      #1;
      sram_ready = 1'b0;
      MEM_R_EN   = 1'b0;
      MEM_W_EN   = 1'b0;
      check("req_drop", {sram_read, sram_write}, 0);
      if (CEN && !is_wr) begin
         vic = !m_v[0][s] ? 0 : (!m_v[1][s] ? 1 : int'(m_lru[s]));
         m_v[vic][s]    = 1'b1;
         m_t[vic][s]    = t;
         m_d[vic][s][0] = blk[31:0];
         m_d[vic][s][1] = blk[63:32];
         m_lru[s]       = (vic == 0);
      end
      if (is_wr && way >= 0) begin
         m_d[way][s][w] = wd;
         m_lru[s]       = (way == 0);
      end
   endtask

   initial begin
      logic [31:0] ra;
      model_clear();
      #1;
      check("rst_ready", ready, 1);
      check("rst_rdata", rdata, 0);
      check("rst_sram_rw", {sram_read, sram_write}, 0);
      check("rst_sram_addr", sram_address, 0);
      check("rst_sram_wdata", sram_wdata, 0);
      @(negedge clk);
      rst = 1'b0;

      run_op(0, 32'd1536, 0, 4);
      run_op(0, 32'd1540, 0, 2);
      run_op(0, 32'd2048, 0, 3);
      run_op(0, 32'd1536, 0, 1);
      run_op(0, 32'd2560, 0, 2);
      run_op(0, 32'd1536, 0, 0);
      run_op(0, 32'd2048, 0, 2);
      run_op(1, 32'd1536, 32'hDEADBEEF, 3);
      run_op(0, 32'd1536, 0, 1);

      // sram_ready with no transaction in flight must be ignored
      @(negedge clk);
      sram_ready = 1'b1;
      #1;
      check("idle_pulse_ready", ready, 1);
      check("idle_pulse_rdata", rdata, 0);
      @(negedge clk);
      sram_ready = 1'b0;
      #1;
      check("idle_pulse_rw", {sram_read, sram_write}, 0);
      run_op(0, 32'd1540, 0, 1);

      // reset during an outstanding miss
      @(negedge clk);
      address  = 32'd1064;
      MEM_R_EN = 1'b1;
      @(negedge clk);
      #1;
      check("rmiss_read_up", sram_read, lookup(32'd1064) < 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_read", sram_read, 0);
      MEM_R_EN = 1'b0;
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      run_op(0, 32'd1064, 0, 2);
      run_op(0, 32'd1536, 0, 1);

      for (int i = 0; i < 150; i++) begin
         ra = 32'd1024 + 32'($urandom_range(0, 3)) * 512 + 32'($urandom_range(0, 3)) * 8
              + 32'($urandom_range(0, 1)) * 4 + 32'($urandom_range(0, 3));
         run_op($urandom_range(0, 3) == 0, ra, $urandom, $urandom_range(0, 4));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
